// File: rtl/aes_package.sv
// aes_package
// Shared AES constants, types and byte/word helpers for the key-schedule
// controller and its expansion step.
//   DATA_WIDTH / WORD_SIZE / NUM_OF_ROUNDS / EXPANSIONED_KEY_SIZE : AES-128 sizes
//   RK_IDX_W, NUM_RK_SLOTS : round-key index width and number of stored keys
//   ks_state_t             : controller FSM states
//   xtime8, sbox, sub_word : GF(2^8) doubling and S-box lookups
package aes_package;

  localparam int DATA_WIDTH           = 128;
  localparam int WORD_SIZE            = 32;
  localparam int NUM_OF_ROUNDS        = 10;
  localparam int EXPANSIONED_KEY_SIZE = 1408;
  localparam int RK_IDX_W             = 4;
  localparam int NUM_RK_SLOTS         = NUM_OF_ROUNDS + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) with the AES polynomial; steps rcon 01,02,..,1b,36.
  function automatic logic [7:0] xtime8(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [WORD_SIZE-1:0] sub_word(input logic [WORD_SIZE-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/key_step.sv
// key_step
// One AES-128 key-expansion step: derives round key N from round key N-1.
// Purely combinational.
//   prev_key [127:0] : previous round key, word w0 in the MSBs
//   rcon     [7:0]   : round constant for this step
//   next_key [127:0] : next round key, same word order
module key_step
  import aes_package::*;
(
  input  logic [DATA_WIDTH-1:0] prev_key,
  input  logic [7:0]            rcon,
  output logic [DATA_WIDTH-1:0] next_key
);

  logic [WORD_SIZE-1:0] w0, w1, w2, w3;
  logic [WORD_SIZE-1:0] t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;

  // RotWord is a one-byte left rotate; the round constant only touches the top byte.
  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
// Iterative AES-128 key schedule: accepts a cipher key, derives round keys
// 1..10 one per cycle through a single key_step, then serves registered
// indexed reads and exposes all eleven keys on a flat bus.
//   clk, rst (async, active-low)
//   key, key_valid, key_ready          : cipher key handshake
//   busy, keys_ready                   : expansion in progress / all keys valid
//   rk_req, rk_idx -> rk_out, rk_valid, rk_err : 1-cycle round-key read port
//   expansioned_key [1407:0]           : slot 0 in the MSBs, slot 10 in the LSBs
module key_schedule_ctrl
  import aes_package::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           key,
  input  logic                            key_valid,
  output logic                            key_ready,
  output logic                            busy,
  output logic                            keys_ready,
  input  logic                            rk_req,
  input  logic [RK_IDX_W-1:0]             rk_idx,
  output logic [DATA_WIDTH-1:0]           rk_out,
  output logic                            rk_valid,
  output logic                            rk_err,
  output logic [EXPANSIONED_KEY_SIZE-1:0] expansioned_key
);

  localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NUM_OF_ROUNDS);

  ks_state_t             state;
  logic [RK_IDX_W-1:0]   wr_idx;
  logic [7:0]            rcon;
  logic [DATA_WIDTH-1:0] slot [NUM_RK_SLOTS];

  logic                  key_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] prev_key;
  logic [DATA_WIDTH-1:0] next_key;
  logic [DATA_WIDTH-1:0] rd_data;

  assign key_ready  = (state != EXPAND);
  assign busy       = (state == EXPAND);
  assign keys_ready = (state == DONE);

  assign key_accept = key_valid && key_ready;
  assign rd_accept  = rk_req && keys_ready;

  // Explicit compare-muxes keep every slot access in range for any 4-bit index.
  always_comb begin
    // NOTE: defaults first in every combinational block so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    prev_key = '0;
    rd_data  = '0;
    for (int i = 0; i < NUM_OF_ROUNDS; i++) begin
      if (wr_idx == RK_IDX_W'(i + 1)) prev_key = slot[i];
    end
    // Indices above 10 match no slot and read as zero.
    for (int i = 0; i < NUM_RK_SLOTS; i++) begin
      if (rk_idx == RK_IDX_W'(i)) rd_data = slot[i];
    end
  end

  key_step u_key_step (
    .prev_key (prev_key),
    .rcon     (rcon),
    .next_key (next_key)
  );

  // Control FSM: sequences the write index and round constant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_idx <= '0;
      rcon   <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values, independent of statement order.
      case (state)
        IDLE, DONE: begin
          if (key_accept) begin
            state  <= EXPAND;
            wr_idx <= RK_IDX_W'(1);
            rcon   <= 8'h01;
          end
        end
        EXPAND: begin
          wr_idx <= wr_idx + RK_IDX_W'(1);
          rcon   <= xtime8(rcon);
          if (wr_idx == LAST_IDX) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-key storage. Slot 0 loads on the handshake; slots 1..10 fill in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the key store is reset on purpose: an aborted expansion must
      // leave no partial key material behind, so this is not a plain RAM.
      for (int i = 0; i < NUM_RK_SLOTS; i++) slot[i] <= '0;
    end else if (key_accept) begin
      slot[0] <= key;
    end else if (busy) begin
      for (int i = 1; i < NUM_RK_SLOTS; i++) begin
        if (wr_idx == RK_IDX_W'(i)) slot[i] <= next_key;
      end
    end
  end

  // Read port. A read coinciding with a new-key handshake sees the old slots
  // because the slot registers only change at the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk_out   <= '0;
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
    end else begin
      rk_valid <= rd_accept;
      rk_err   <= rd_accept && (rk_idx > LAST_IDX);
      if (rd_accept) rk_out <= rd_data;
    end
  end

  for (genvar g = 0; g < NUM_RK_SLOTS; g++) begin : g_flat
    assign expansioned_key[(NUM_RK_SLOTS-1-g)*DATA_WIDTH +: DATA_WIDTH] = slot[g];
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  key;
  logic          key_valid;
  logic          key_ready;
  logic          busy;
  logic          keys_ready;
  logic          rk_req;
  logic [3:0]    rk_idx;
  logic [127:0]  rk_out;
  logic          rk_valid;
  logic          rk_err;
  logic [1407:0] expansioned_key;

  key_schedule_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .key             (key),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .busy            (busy),
    .keys_ready      (keys_ready),
    .rk_req          (rk_req),
    .rk_idx          (rk_idx),
    .rk_out          (rk_out),
    .rk_valid        (rk_valid),
    .rk_err          (rk_err),
    .expansioned_key (expansioned_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp_out;
    logic         exp_err;
  } rd_vec_t;

  logic [127:0] fips_rk [11];
  rd_vec_t      vecs [13];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_cyc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake a key and count edges (handshake edge included) until keys_ready.
  task automatic load_key(input logic [127:0] k, output int cycles);
    key       = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    cycles    = 1;
    while (!keys_ready && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic read_one(input logic [3:0] idx, input logic [127:0] exp, input string name);
    rk_req = 1'b1;
    rk_idx = idx;
    tick();
    rk_req = 1'b0;
    check({name, "_valid"}, 128'(rk_valid), 128'd1);
    check({name, "_data"}, rk_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) vecs[i] = '{idx: 4'(i), exp_out: fips_rk[i], exp_err: 1'b0};
    vecs[11] = '{idx: 4'd15, exp_out: 128'd0, exp_err: 1'b1};
    vecs[12] = '{idx: 4'd11, exp_out: 128'd0, exp_err: 1'b1};

    rst = 1'b0; key = '0; key_valid = 1'b0; rk_req = 1'b0; rk_idx = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Reset state.
    check("rst_key_ready",  128'(key_ready),  128'd1);
    check("rst_busy",       128'(busy),       128'd0);
    check("rst_keys_ready", 128'(keys_ready), 128'd0);
    check("rst_rk_valid",   128'(rk_valid),   128'd0);
    check("rst_rk_out",     rk_out,           128'd0);
    check("rst_ek_nonzero", 128'(|expansioned_key), 128'd0);

    // Read while idle is dropped.
    rk_req = 1'b1; rk_idx = 4'd0;
    tick();
    rk_req = 1'b0;
    check("idle_read_dropped", 128'(rk_valid), 128'd0);

    // FIPS-197 key: latency and full table of reads, back-to-back.
    load_key(fips_rk[0], n_cyc);
    check("fips_latency", 128'(n_cyc), 128'd11);
    check("fips_key_ready", 128'(key_ready), 128'd1);
    for (int i = 0; i < 13; i++) begin
      rk_req = 1'b1;
      rk_idx = vecs[i].idx;
      tick();
      check($sformatf("b2b_valid_%0d", vecs[i].idx), 128'(rk_valid), 128'd1);
      check($sformatf("b2b_data_%0d", vecs[i].idx), rk_out, vecs[i].exp_out);
      check($sformatf("b2b_err_%0d", vecs[i].idx), 128'(rk_err), 128'(vecs[i].exp_err));
    end
    rk_req = 1'b0;
    tick();
    check("read_pulse_ends", 128'(rk_valid), 128'd0);
    for (int i = 0; i < 11; i++)
      check($sformatf("ek_slot_%0d", i), expansioned_key[(10-i)*128 +: 128], fips_rk[i]);

    // All-zero key, loaded from DONE.
    load_key(128'd0, n_cyc);
    check("zero_latency", 128'(n_cyc), 128'd11);
    read_one(4'd1,  128'h62636363626363636263636362636363, "zero_rk1");
    read_one(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10");

    // Second key held valid during EXPAND is not taken until DONE.
    key = 128'd0; key_valid = 1'b1;
    tick();
    key = fips_rk[0];
    check("hold_busy", 128'(busy), 128'd1);
    check("hold_key_ready", 128'(key_ready), 128'd0);
    rk_req = 1'b1; rk_idx = 4'd0;
    tick();
    rk_req = 1'b0;
    check("expand_read_dropped", 128'(rk_valid), 128'd0);
    n_cyc = 2;
    while (!keys_ready && n_cyc < 40) begin
      tick();
      n_cyc++;
    end
    check("hold_first_latency", 128'(n_cyc), 128'd11);
    tick();
    key_valid = 1'b0;
    check("hold_second_accepted", 128'(busy), 128'd1);
    check("hold_keys_ready_low", 128'(keys_ready), 128'd0);
    n_cyc = 1;
    while (!keys_ready && n_cyc < 40) begin
      tick();
      n_cyc++;
    end
    check("hold_second_latency", 128'(n_cyc), 128'd11);
    read_one(4'd1, fips_rk[1], "hold_rk1");

    // Reset in the middle of an expansion.
    key = 128'd0; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_key_ready",  128'(key_ready),  128'd1);
    check("mid_rst_busy",       128'(busy),       128'd0);
    check("mid_rst_keys_ready", 128'(keys_ready), 128'd0);
    check("mid_rst_rk_valid",   128'(rk_valid),   128'd0);
    check("mid_rst_rk_err",     128'(rk_err),     128'd0);
    check("mid_rst_rk_out",     rk_out,           128'd0);
    check("mid_rst_ek_nonzero", 128'(|expansioned_key), 128'd0);
    tick();
    rst = 1'b1;
    tick();
    load_key(fips_rk[0], n_cyc);
    check("reissue_latency", 128'(n_cyc), 128'd11);
    read_one(4'd10, fips_rk[10], "reissue_rk10");

    // Read and new key on the same edge in DONE.
    rk_req = 1'b1; rk_idx = 4'd0;
    key = 128'd0; key_valid = 1'b1;
    tick();
    rk_req = 1'b0; key_valid = 1'b0;
    check("same_edge_valid", 128'(rk_valid), 128'd1);
    check("same_edge_old_key", rk_out, fips_rk[0]);
    check("same_edge_keys_ready", 128'(keys_ready), 128'd0);
    check("same_edge_busy", 128'(busy), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
